// File: rtl/daq_arbiter_pkg.sv
// daq_arbiter_pkg: shared DAQ word width, type codes, arbiter state and saturating add
package daq_arbiter_pkg;
  localparam int DAQ_W = 32;
  typedef enum logic [7:0] {
    DAQT_UART        = 8'h01,
    DAQT_STEP        = 8'h02,
    DAQT_ENDSTOP     = 8'h03,
    DAQT_ARB_TIMEOUT = 8'hFF
  } daqt_e;
  typedef enum logic {IDLE, XFER} arb_state_e;
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/daq_arbiter_if.sv
// daq_arbiter_if: producer req/grant/valid/end bundle plus host readout valid/ready
interface daq_arbiter_if #(parameter int NSRC = 4);
  import daq_arbiter_pkg::*;
  logic [NSRC-1:0] daq_req, daq_grant, daq_valid, daq_end;
  logic [DAQ_W*NSRC-1:0] daq_data;
  logic [DAQ_W-1:0] out_data;
  logic out_valid, out_ready;
  modport slave (
    input  daq_req, daq_data, daq_valid, daq_end, out_ready,
    output daq_grant, out_data, out_valid
  );
  modport master (
    output daq_req, daq_data, daq_valid, daq_end, out_ready,
    input  daq_grant, out_data, out_valid
  );
endinterface

// File: rtl/daq_fifo.sv
// daq_fifo: first-word-fall-through synchronous FIFO with free-space count
module daq_fifo import daq_arbiter_pkg::*; #(
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DAQ_W-1:0]       push_data,
  input  logic                   pop,
  output logic [DAQ_W-1:0]       pop_data,
  output logic                   pop_valid,
  output logic [$clog2(DEPTH):0] free
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  logic [DAQ_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_pop;
  assign pop_valid = cnt != '0;
  assign do_pop = pop && pop_valid;
  assign pop_data = mem[rp];
  assign free = DEPTH_V - cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= push_data;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && cnt == DEPTH_V));
endmodule

// File: rtl/daq_arbiter.sv
// daq_arbiter: round-robin grant of DAQ producers into a FIFO, with drop/timeout/error counters
module daq_arbiter import daq_arbiter_pkg::*; #(
  parameter int NSRC       = 4,
  parameter int MAX_PKT    = 4,
  parameter int FIFO_DEPTH = 256,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  daq_arbiter_if.slave  bus,
  output logic [15:0]   ovf_cnt,
  output logic [15:0]   tmo_cnt,
  output logic [15:0]   err_cnt
);
  localparam int IW = NSRC > 1 ? $clog2(NSRC) : 1;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  arb_state_e state;
  logic [NSRC-1:0] req_q, grant, bad;
  logic [IW-1:0] ptr, g, win, nxt;
  logic [CW-1:0] wc;
  logic [TW-1:0] timer;
  logic [FW-1:0] free;
  logic [DAQ_W-1:0] push_data;
  logic [DAQ_W-1:0] src_data [NSRC];
  logic push, found, room;
  function automatic logic [IW:0] rr_pick(input logic [NSRC-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    int k;
    res = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      k = (int'(p) + i) % NSRC;
      if (r[k[IW-1:0]]) res = {1'b1, k[IW-1:0]};
    end
    return res;
  endfunction
  function automatic logic [4:0] ones(input logic [NSRC-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NSRC; i++) n = n + 5'(v[i]);
    return n;
  endfunction
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src_data[i] = bus.daq_data[DAQ_W*i +: DAQ_W];
  end
  assign {found, win} = rr_pick(req_q, ptr);
  // a word still in the write register has not reached the FIFO count yet
  assign room = int'(free) - int'(push) > MAX_PKT;
  assign nxt = (g == IW'(NSRC - 1)) ? '0 : g + IW'(1);
  assign bad = bus.daq_valid & ~grant;
  assign bus.daq_grant = grant;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      grant     <= '0;
      ptr       <= '0;
      g         <= '0;
      wc        <= '0;
      timer     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      ovf_cnt   <= '0;
      tmo_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      req_q   <= bus.daq_req;
      push    <= 1'b0;
      err_cnt <= sat_add(err_cnt, ones(bad));
      if (state == IDLE) begin
        if (found && room) begin
          state <= XFER;
          g     <= win;
          grant <= NSRC'(1) << win;
          wc    <= '0;
          timer <= '0;
        end
      end else begin
        if (bus.daq_valid[g]) begin
          if (wc < CW'(MAX_PKT)) begin
            push      <= 1'b1;
            push_data <= src_data[g];
            wc        <= wc + CW'(1);
          end else ovf_cnt <= sat_add(ovf_cnt, 5'd1);
        end
        if (bus.daq_valid[g] && bus.daq_end[g]) begin
          state <= IDLE;
          grant <= '0;
          ptr   <= nxt;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          push      <= 1'b1;
          push_data <= {DAQT_ARB_TIMEOUT, 24'(g)};
          tmo_cnt   <= sat_add(tmo_cnt, 5'd1);
          state     <= IDLE;
          grant     <= '0;
          ptr       <= nxt;
        end else timer <= timer + TW'(1);
      end
    end
  daq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk,
    .rst_n,
    .push,
    .push_data,
    .pop       (bus.out_ready),
    .pop_data  (bus.out_data),
    .pop_valid (bus.out_valid),
    .free
  );
endmodule

// File: doc/daq_arbiter.md
# daq_arbiter

Collects DAQ packets from up to NSRC producer blocks (UART loggers, step/endstop samplers) using the req/grant/valid/end handshake. Grants one source at a time in round-robin order and stores the packet words in an internal FIFO. Presents the FIFO to the host-readout path over valid/ready. Producers cannot stall, so a grant is issued only when the FIFO can absorb a full packet plus one marker word.

## Interface
Parameters:
- NSRC, 4: number of producer ports, 1..16
- MAX_PKT, 4: maximum words per packet
- FIFO_DEPTH, 256: FIFO depth in 32-bit words, power of two, ≥ 2*(MAX_PKT+1)
- TIMEOUT, 64: cycles allowed from grant to end word

Ports:
- clk  in  1  system clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- daq_req  in  NSRC  per-source request
- daq_grant  out  NSRC  one-hot grant, level
- daq_data  in  32*NSRC  per-source word; source i uses bits [32i+31:32i]
- daq_valid  in  NSRC  per-source word strobe
- daq_end  in  NSRC  per-source last-word flag, qualified by valid
- out_data  out  32  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer pops the head when out_valid && out_ready
- ovf_cnt  out  16  words dropped for exceeding MAX_PKT, saturating
- tmo_cnt  out  16  grant timeouts, saturating
- err_cnt  out  16  valid strobes from non-granted sources, saturating

## Operation
- Reset: daq_grant=0, out_valid=0, all counters=0, round-robin pointer=0, FIFO empty, state IDLE.
- States: IDLE, XFER.
- IDLE → XFER when any req is set and fifo_free ≥ MAX_PKT+1.
  - The winner is the first requesting index at or after the pointer, scanning upward with wrap.
  - On entry: daq_grant[winner] <= 1, timer cleared.
- XFER, granted source g:
  - daq_valid[g] writes daq_data[g] unchanged if fewer than MAX_PKT words have been written this packet; otherwise the word is dropped and ovf_cnt increments.
  - daq_valid[g] && daq_end[g]: grant cleared, pointer <= (g+1) mod NSRC, state IDLE. The end word itself is written or dropped under the same MAX_PKT rule.
  - Timer reaches TIMEOUT before the end word: grant cleared, marker word 0xFF0000_00 | g written, tmo_cnt increments, pointer advances, state IDLE.
- Requests are not required to stay high after grant; producers drop req on seeing grant.
- daq_valid from any non-granted source, in any state, is ignored and increments err_cnt once per cycle per offending source.
- FIFO push and pop in the same cycle: occupancy unchanged. The reservation rule guarantees a push never hits a full FIFO. Overflow on push is an assertion failure, not a handled case.
- Reset mid-packet: grant drops asynchronously, FIFO contents are discarded, counters clear.

## Timing
- req sampled high at edge N in IDLE with space → daq_grant high after edge N+1.
- Grant holds until the edge that samples the end word (or timeout). It is low for at least one cycle before any new grant, so a source may use level grant.
- A word sampled at edge M is visible on out_data/out_valid after edge M+1 if the FIFO was empty (one-cycle write latency).
- out_data is stable while out_valid && !out_ready.
- Timer counts cycles after grant assertion. Timeout fires on the edge where timer == TIMEOUT-1 and no end word is sampled. An end word on that same edge wins: normal completion, no timeout.

## Structure
- Shared daq package holds:
  - the DAQT_* type codes, including DAQT_ARB_TIMEOUT = 0xFF
  - the 32-bit word width constant
- Sub-module daq_fifo:
  - synchronous FIFO, first-word-fall-through
  - ports: push/data in, pop/data/valid out, free count out
  - async active-low reset
- Round-robin pick is a combinational function inside daq_arbiter.

## Test plan
- Source 1 sends a 2-word packet (0x0A12_3456 then 0x0000_0001, end on second) → both words out in order; grant high exactly from edge N+1 through the end edge; pointer = 2.
- Sources 0, 1, 2 request simultaneously with pointer 0 → grant order 0, 1, 2, each single-word packet; one idle grant cycle between each.
- FIFO filled to free = MAX_PKT with out_ready=0 → no grant despite req. Pop one word → grant on the following edge.
- Granted source sends 6 words with MAX_PKT=4 → 4 words stored, ovf_cnt = 2, grant released on end.
- Granted source never asserts valid → after 64 cycles the marker 0xFF000000|g is emitted, tmo_cnt = 1, next requester granted.
- Source 3 pulses valid while source 0 is granted → err_cnt = 1, FIFO contents unaffected. Assert rst_n low mid-packet → all outputs at reset values immediately.
